// File: rtl/bus_host_arbiter_pkg.sv
// Shared constants and types for the two-host bus arbiter.
//   NumHosts       : number of requesting hosts (fixed at 2)
//   MaxOutstanding : largest supported depth of the in-flight ID FIFO
//   host_idx_t     : index of one host
package bus_host_arbiter_pkg;

  localparam int NumHosts       = 2;
  localparam int MaxOutstanding = 4;
  localparam int PtrW           = 2;  // addresses MaxOutstanding entries
  localparam int CntW           = 3;  // counts 0..MaxOutstanding

  typedef logic host_idx_t;

endpackage

// File: rtl/bus_host_arbiter_id_fifo.sv
// In-order FIFO of host indices. Each entry records which host owns one
// in-flight device transaction.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write push_id_i (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   full_o       : Depth entries held
//   empty_o      : no entries held
//   head_o       : oldest entry, valid when empty_o is low
module bus_host_arbiter_id_fifo
  import bus_host_arbiter_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  host_idx_t push_id_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output host_idx_t head_o
);

  host_idx_t       mem_q [MaxOutstanding];
  host_idx_t       mem_d [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            do_push, do_pop;

  // Pointers wrap at Depth, not at the physical array size.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (cnt_q == CntW'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_id_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/bus_host_arbiter.sv
// Two-host arbiter in front of a single pipelined device port.
// Requests pass through combinationally to the device; the owner of each
// accepted transaction is queued so that in-order responses are routed back.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   host_req_i, host_we_i     : per-host request / write enable
//   host_addr_i, host_wdata_i : per-host 32-bit fields, host h at [32*h +: 32]
//   host_be_i                 : per-host byte enables, host h at [4*h +: 4]
//   host_gnt_o                : handshake accepted for that host this cycle
//   host_rvalid_o, host_err_o : response valid / error for that host
//   host_rdata_o              : read data, host h at [32*h +: 32]
//   dev_*                     : device-side request and response channels
//   spurious_rsp_o            : response arrived with nothing outstanding
module bus_host_arbiter
  import bus_host_arbiter_pkg::*;
#(
  parameter int   NumOutstanding = 2,
  parameter logic FixedPrio      = 1'b0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumHosts-1:0]      host_req_i,
  input  logic [NumHosts-1:0]      host_we_i,
  input  logic [NumHosts*32-1:0]   host_addr_i,
  input  logic [NumHosts*32-1:0]   host_wdata_i,
  input  logic [NumHosts*4-1:0]    host_be_i,
  output logic [NumHosts-1:0]      host_gnt_o,
  output logic [NumHosts-1:0]      host_rvalid_o,
  output logic [NumHosts-1:0]      host_err_o,
  output logic [NumHosts*32-1:0]   host_rdata_o,
  output logic                     dev_req_o,
  output logic                     dev_we_o,
  output logic [31:0]              dev_addr_o,
  output logic [31:0]              dev_wdata_o,
  output logic [3:0]               dev_be_o,
  input  logic                     dev_gnt_i,
  input  logic                     dev_rvalid_i,
  input  logic                     dev_err_i,
  input  logic [31:0]              dev_rdata_i,
  output logic                     spurious_rsp_o
);

  host_idx_t prio_q, prio_d;
  host_idx_t winner;
  host_idx_t head_id;
  logic      any_req;
  logic      fifo_full, fifo_empty;
  logic      handshake;
  logic      rsp_valid;

  // Winner only depends on prio_q and the request vector, so it stays put
  // while a held request waits for dev_gnt_i.
  always_comb begin
    if (FixedPrio) begin
      winner = host_req_i[0] ? 1'b0 : 1'b1;
    end else begin
      winner = host_req_i[prio_q] ? prio_q : ~prio_q;
    end
  end

  assign any_req   = |host_req_i;
  // Full blocks requests even if a pop frees a slot this cycle; this keeps
  // dev_rvalid_i off the request path.
  assign dev_req_o = any_req & ~fifo_full & ~rst_i;
  assign handshake = dev_req_o & dev_gnt_i;

  always_comb begin
    dev_we_o    = 1'b0;
    dev_addr_o  = '0;
    dev_wdata_o = '0;
    dev_be_o    = '0;
    if (any_req) begin
      dev_we_o    = host_we_i[winner];
      dev_addr_o  = winner ? host_addr_i[63:32]  : host_addr_i[31:0];
      dev_wdata_o = winner ? host_wdata_i[63:32] : host_wdata_i[31:0];
      dev_be_o    = winner ? host_be_i[7:4]      : host_be_i[3:0];
    end
  end

  always_comb begin
    host_gnt_o = '0;
    if (handshake) begin
      host_gnt_o[winner] = 1'b1;
    end
  end

  // The head is read before this cycle's push lands, so a response in the
  // grant cycle can never be matched to the transaction just granted.
  assign rsp_valid      = dev_rvalid_i & ~fifo_empty & ~rst_i;
  assign spurious_rsp_o = dev_rvalid_i & fifo_empty & ~rst_i;

  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    host_rdata_o  = '0;
    if (rsp_valid) begin
      host_rvalid_o[head_id] = 1'b1;
      host_err_o[head_id]    = dev_err_i;
      if (head_id) host_rdata_o[63:32] = dev_rdata_i;
      else         host_rdata_o[31:0]  = dev_rdata_i;
    end
  end

  // Round-robin: the loser of the last accepted handshake goes first next.
  always_comb begin
    prio_d = prio_q;
    if (handshake) begin
      prio_d = ~winner;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else begin
      prio_q <= prio_d;
    end
  end

  bus_host_arbiter_id_fifo #(
    .Depth (NumOutstanding)
  ) u_id_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push_i    (handshake),
    .push_id_i (winner),
    .pop_i     (rsp_valid),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .head_o    (head_id)
  );

endmodule
